// File: rtl/pio_wide_master.sv
// pio_wide_master: turns one wide read/write request into an ordered LSB-then-MSB pair of
// 32-bit PIO accesses, qualifies each phase on the mem_ack rising edge and bounds it with a timeout.
module pio_wide_master #(
    parameter int          WIDTH       = 50,
    parameter int          DEPTH_NBITS = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          TMO_NBITS   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_wr,
    input  logic [DEPTH_NBITS-1:0] req_idx,
    input  logic [WIDTH-1:0]       req_wdata,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic [31:0]            reg_addr,
    output logic [31:0]            reg_din,
    output logic                   reg_rd,
    output logic                   reg_wr,
    output logic                   reg_ms,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata
);
    typedef enum logic [2:0] {IDLE, LSB_ISSUE, LSB_WAIT, MSB_ISSUE, MSB_WAIT, DONE} state_t;
    state_t state, state_n;
    logic live, wr_q, ack_d1, err_q, issue, tmo, ack_rise, cnt_max, busy;
    logic [WIDTH-33:0] wdata_hi;
    logic [31:0] rd_lo;
    logic [TMO_NBITS-1:0] cnt;
    assign ack_rise  = mem_ack & ~ack_d1;
    assign cnt_max   = &cnt;
    assign busy      = state != IDLE && state != DONE;
    // live keeps req_ready low while reset is asserted even though the FSM sits in IDLE
    assign req_ready = live && state == IDLE;
    assign rsp_valid = state == DONE;
    assign rsp_err   = rsp_valid & err_q;
    assign reg_ms    = issue;
    assign reg_rd    = issue & ~wr_q;
    assign reg_wr    = issue & wr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE: state_n = (live && req_valid) ? LSB_ISSUE : IDLE;
            LSB_ISSUE, MSB_ISSUE: begin
                tmo     = cnt_max;
                issue   = !cnt_max && !mem_ack;
                state_n = tmo ? DONE : !issue ? state : state == LSB_ISSUE ? LSB_WAIT : MSB_WAIT;
            end
            LSB_WAIT, MSB_WAIT: begin
                tmo     = !ack_rise && cnt_max;
                state_n = tmo ? DONE : !ack_rise ? state : state == LSB_WAIT ? MSB_ISSUE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            ack_d1    <= 1'b0;
            cnt       <= '0;
            wr_q      <= 1'b0;
            wdata_hi  <= '0;
            rd_lo     <= '0;
            err_q     <= 1'b0;
            rsp_rdata <= '0;
            reg_addr  <= '0;
            reg_din   <= '0;
        end else begin
            live   <= 1'b1;
            ack_d1 <= mem_ack;
            cnt    <= ((state_n == LSB_ISSUE || state_n == MSB_ISSUE) && state_n != state) ? '0 :
                      busy ? cnt + 1'b1 : cnt;
            if (state == IDLE && state_n == LSB_ISSUE) begin
                wr_q     <= req_wr;
                wdata_hi <= req_wdata[WIDTH-1:32];
                reg_addr <= BASE_ADDR | (32'(req_idx) << 3);
                reg_din  <= req_wr ? req_wdata[31:0] : '0;
            end
            if (state == LSB_WAIT && ack_rise) begin
                rd_lo    <= mem_rdata;
                reg_addr <= reg_addr | 32'd4;
                reg_din  <= wr_q ? 32'(wdata_hi) : '0;
            end
            if (state_n == DONE) begin
                err_q     <= tmo;
                rsp_rdata <= (tmo || wr_q) ? '0 : {mem_rdata[WIDTH-33:0], rd_lo};
            end
        end
    end
endmodule

// File: tb/tb_pio_wide_master.sv
// tb_pio_wide_master: directed table, random traffic against a request-level memory model,
// plus timeout, back-to-back and mid-sequence reset sequences.
module tb_pio_wide_master;
    localparam int W = 50, DN = 10, TN = 4;
    localparam logic [31:0] BASE = 32'h0004_0000;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_wr = 1'b0;
    logic [DN-1:0] req_idx = '0;
    logic [W-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [W-1:0] rsp_rdata;
    logic [31:0] reg_addr, reg_din;
    logic reg_rd, reg_wr, reg_ms;
    logic mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    pio_wide_master #(.WIDTH(W), .DEPTH_NBITS(DN), .BASE_ADDR(BASE), .TMO_NBITS(TN)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_idx(req_idx),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd),
        .reg_wr(reg_wr), .reg_ms(reg_ms), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass = 0, total = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] din; bit wr; int c; } stb_t;
    stb_t stq[$];
    int nrsp = 0;

    // slave: behavioural wide memory, LSB write buffered, MSB write commits, LSB read caches MSB
    int s_dly = 3, s_hold = 1, pend = 0, cd = 0, left = 0;
    logic [31:0] s_rd, buf_lo;
    logic [W-33:0] cache_hi;
    logic [W-1:0] slv_mem [int];

    initial forever begin
        @(negedge clk);
        if (rsp_valid) nrsp++;
        if (reg_rd || reg_wr) chk("ms_with_strobe", reg_ms, 1);
        if (reg_ms) begin
            int si;
            logic [W-1:0] v;
            chk("strobe_one_hot", reg_rd ^ reg_wr, 1);
            chk("strobe_ack_low", mem_ack, 0);
            stq.push_back('{reg_addr, reg_din, reg_wr, cyc});
            si = int'((reg_addr - BASE) >> 3) & 1023;
            v = slv_mem.exists(si) ? slv_mem[si] : '0;
            if (reg_wr && !reg_addr[2]) buf_lo = reg_din;
            if (reg_wr && reg_addr[2]) slv_mem[si] = {reg_din[W-33:0], buf_lo};
            if (reg_rd && !reg_addr[2]) begin s_rd = v[31:0]; cache_hi = v[W-1:32]; end
            if (reg_rd && reg_addr[2]) s_rd = 32'(cache_hi);
            pend = 1;
            cd = s_dly;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend = 0; left = 0; mem_ack = 1'b0;
        end else begin
            if (left > 0) begin left--; if (left == 0) mem_ack = 1'b0; end
            if (pend != 0) begin
                if (cd == 0) begin mem_ack = 1'b1; mem_rdata = s_rd; left = s_hold; pend = 0; end
                else cd--;
            end
            if (!mem_ack) mem_rdata = $urandom;
        end
    end

    logic [W-1:0] ref_mem [int];
    function automatic logic [W-1:0] model_rd(int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    endfunction

    task automatic wait_rsp(output int t);
        int k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid && k < 100);
        chk("rsp_valid", rsp_valid, 1);
        t = cyc;
    endtask

    task automatic run_req(bit wr, logic [DN-1:0] idx, logic [W-1:0] wd, int dly, int hold,
                           bit exp_err, logic [W-1:0] exp_rd, int exp_n, output int t_done);
        int k = 0;
        logic [31:0] a;
        s_dly = dly; s_hold = hold;
        stq.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = wr; req_idx = idx; req_wdata = wd;
        do begin @(negedge clk); k++; end while (!req_ready && k < 50);
        chk("accept", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp(t_done);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("n_strobes", stq.size(), exp_n);
        a = BASE | (32'(idx) << 3);
        foreach (stq[i]) begin
            chk("stb_addr", stq[i].addr, a | (i == 0 ? 32'd0 : 32'd4));
            chk("stb_wr", stq[i].wr, wr);
            if (wr) chk("stb_din", stq[i].din, i == 0 ? wd[31:0] : 32'(wd[W-1:32]));
        end
    endtask

    typedef struct { bit wr; bit [DN-1:0] idx; bit [W-1:0] wd; int dly; int hold; bit [W-1:0] exp; } vec_t;
    vec_t vt[6];

    initial begin
        int t, n0, k;
        vt[0] = '{1'b1, 10'd5,   50'h3_ABCD_1234_5678, 3, 1, 50'h0};
        vt[1] = '{1'b0, 10'd5,   50'h0,                3, 1, 50'h3_ABCD_1234_5678};
        vt[2] = '{1'b1, 10'h3FF, 50'h2_FFFF_0000_FFFF, 0, 8, 50'h0};
        vt[3] = '{1'b0, 10'h3FF, 50'h0,                1, 8, 50'h2_FFFF_0000_FFFF};
        vt[4] = '{1'b1, 10'd0,   50'h1_0000_0000_0001, 2, 2, 50'h0};
        vt[5] = '{1'b0, 10'd0,   50'h0,                4, 3, 50'h1_0000_0000_0001};

        #3;
        chk("rst_ctl", {req_ready, rsp_valid, rsp_err, reg_rd, reg_wr, reg_ms}, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        foreach (vt[i]) begin
            run_req(vt[i].wr, vt[i].idx, vt[i].wd, vt[i].dly, vt[i].hold, 1'b0, vt[i].exp, 2, t);
            if (vt[i].wr) ref_mem[int'(vt[i].idx)] = vt[i].wd;
        end

        // dead slave: ack arrives only long after the timeout and must be ignored
        run_req(1'b0, 10'd5, '0, 40, 1, 1'b1, '0, 1, t);
        if (stq.size() > 0) chk("tmo_latency", t - stq[0].c, 16);
        n0 = nrsp;
        repeat (50) @(negedge clk);
        chk("late_ack_no_rsp", nrsp, n0);
        chk("late_ack_no_strobe", stq.size(), 1);

        for (int i = 0; i < 40; i++) begin
            bit wr = 1'($urandom_range(0, 1));
            int idx = $urandom_range(0, 7);
            logic [W-1:0] wd = W'({$urandom, $urandom});
            run_req(wr, DN'(idx), wd, $urandom_range(0, 4), $urandom_range(1, 6), 1'b0,
                    wr ? '0 : model_rd(idx), 2, t);
            if (wr) ref_mem[idx] = wd;
        end

        // back-to-back: write then read of the same entry with req_valid held high
        s_dly = 1; s_hold = 1; stq.delete(); k = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b1; req_idx = 10'd7; req_wdata = 50'h2_5A5A_C3C3_0F0F;
        do begin @(negedge clk); k++; end while (!req_ready && k < 50);
        @(posedge clk); #1 req_wr = 1'b0;
        wait_rsp(t);
        chk("b2b_busy_at_done", req_ready, 0);
        @(negedge clk);
        chk("b2b_ready_after_done", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp(t);
        chk("b2b_rdata", rsp_rdata, 50'h2_5A5A_C3C3_0F0F);
        chk("b2b_n_strobes", stq.size(), 4);
        if (stq.size() == 4) begin
            chk("b2b_msb_din", stq[1].din, 32'h0002_5A5A);
            chk("b2b_rd_addr", stq[3].addr, BASE | 32'h3C);
        end
        ref_mem[7] = 50'h2_5A5A_C3C3_0F0F;

        // reset during MSB_WAIT
        s_dly = 6; s_hold = 1; stq.delete(); k = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = 1'b0; req_idx = 10'd3;
        @(posedge clk); #1 req_valid = 1'b0;
        while (stq.size() < 2 && k < 60) begin @(negedge clk); k++; end
        chk("rst_reached_msb", stq.size(), 2);
        @(negedge clk);
        n0 = nrsp;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {req_ready, rsp_valid, rsp_err, reg_rd, reg_wr, reg_ms}, 0);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_din", reg_din, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        pend = 0; left = 0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_rsp", nrsp, n0);
        run_req(1'b0, 10'd5, '0, 2, 1, 1'b0, model_rd(5), 2, t);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
